// File: rtl/branch_unit_ras.sv
// Branch resolution unit: owns the fetch PC, registers ALU condition flags, resolves
// jumps/calls/returns/conditional branches and inserts a one-cycle flush bubble after
// every taken branch.
// Optional feature: define BRANCH_RAS_EN to build the hardware return-address stack;
// without it, returns always target return_addr and ras_ovf/ras_udf are tied low.
module branch_unit_ras #(
    parameter int unsigned           XLEN      = 32,
    parameter int unsigned           RAS_DEPTH = 4,
    parameter logic [XLEN-1:0]       RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      branch,
    input  logic [5:0]      fn_code,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] return_addr,
    input  logic [4:0]      flags,
    input  logic            flags_we,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] write_to_reg,
    output logic            reg_we,
    output logic            taken,
    output logic            flush,
    output logic            ras_ovf,
    output logic            ras_udf
);

    // The RAS pointer arithmetic relies on natural wrap-around.
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RAS_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] wtr_q;
    logic            reg_we_q;
    logic            taken_q;
    logic [4:0]      flags_q;

    logic            accept;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] pc_imm;
    logic [XLEN-1:0] ret_target;
    logic [XLEN-1:0] next_pc;
    logic            sel_imm;
    logic            is_call;
    logic            is_ret;
    logic            taken_d;

    assign accept = br_valid && br_ready;

    // Decode the branch class and select the next PC; taken is by selection, not value.
    always_comb begin
        pc_inc  = pc_q + XLEN'(1);
        pc_imm  = pc_q + imm;
        sel_imm = 1'b0;
        is_call = 1'b0;
        is_ret  = 1'b0;
        case (branch)
            3'b001: begin
                if (fn_code == 6'b000000) begin
                    sel_imm = 1'b1;
                end else if (fn_code == 6'b000001) begin
                    is_ret = 1'b1;
                end
            end
            3'b010: sel_imm = flags_q[0];
            3'b011: sel_imm = flags_q[1];
            3'b100: sel_imm = flags_q[2];
            3'b110: sel_imm = flags_q[3];
            3'b111: sel_imm = flags_q[4];
            3'b101: begin
                sel_imm = 1'b1;
                is_call = 1'b1;
            end
            default: ;
        endcase
        taken_d = sel_imm || is_ret;
        if (is_ret) begin
            next_pc = ret_target;
        end else if (sel_imm) begin
            next_pc = pc_imm;
        end else begin
            next_pc = pc_inc;
        end
    end

`ifdef BRANCH_RAS_EN
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PtrW-1:0] ras_ptr_q;
    logic [CntW-1:0] ras_cnt_q;
    logic [PtrW-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_push;
    logic            ras_pop;
    logic            ovf_q;
    logic            udf_q;

    // ras_ptr_q is the next free slot; when full it also names the oldest entry.
    always_comb begin
        ras_top    = ras_ptr_q - PtrW'(1);
        ras_empty  = (ras_cnt_q == '0);
        ras_full   = (ras_cnt_q == CntW'(RAS_DEPTH));
        ras_push   = accept && is_call;
        ras_pop    = accept && is_ret;
        ret_target = ras_empty ? return_addr : ras_mem[ras_top];
    end

    // RAS storage, written on every accepted call (overwrites oldest when full).
    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_mem[ras_ptr_q] <= pc_inc;
        end
    end

    // RAS pointer/count and the overflow/underflow pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            ovf_q <= ras_push && ras_full;
            udf_q <= ras_pop && ras_empty;
            if (ras_push) begin
                ras_ptr_q <= ras_ptr_q + PtrW'(1);
                if (!ras_full) begin
                    ras_cnt_q <= ras_cnt_q + CntW'(1);
                end
            end else if (ras_pop && !ras_empty) begin
                ras_ptr_q <= ras_top;
                ras_cnt_q <= ras_cnt_q - CntW'(1);
            end
        end
    end

    assign ras_ovf = ovf_q;
    assign ras_udf = udf_q;
`else
    assign ret_target = return_addr;
    assign ras_ovf    = 1'b0;
    assign ras_udf    = 1'b0;
`endif

    // Condition flags are captured independently of the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (flags_we) begin
            flags_q <= flags;
        end
    end

    // PC, link value and per-instruction pulses update on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wtr_q    <= '0;
            reg_we_q <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            reg_we_q <= accept && is_call;
            taken_q  <= accept && taken_d;
            if (accept) begin
                pc_q <= next_pc;
            end
            if (accept && is_call) begin
                wtr_q <= pc_inc;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a taken accept costs one bubble cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (accept && taken_d) state_d = StFlush;
            StFlush: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // FSM outputs; ready is held low while reset is asserted.
    always_comb begin
        br_ready = 1'b0;
        flush    = 1'b0;
        unique case (state_q)
            StRun:   br_ready = !rst;
            StFlush: flush = 1'b1;
            default: ;
        endcase
    end

    assign pc           = pc_q;
    assign write_to_reg = wtr_q;
    assign reg_we       = reg_we_q;
    assign taken        = taken_q;

endmodule

// File: tb/tb_branch_unit_ras.sv
// Scoreboard bench for branch_unit_ras (RESET_PC=0x100, RAS_DEPTH=4). Expectations
// depend on whether BRANCH_RAS_EN is defined for the build.
module tb_branch_unit_ras;

    localparam logic [31:0] RstPc = 32'h100;
`ifdef BRANCH_RAS_EN
    localparam bit RasEn = 1'b1;
`else
    localparam bit RasEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [2:0]  branch = '0;
    logic [5:0]  fn_code = '0;
    logic [31:0] imm = '0;
    logic [31:0] return_addr = '0;
    logic [4:0]  flags = '0;
    logic        flags_we = 1'b0;
    logic [31:0] pc;
    logic [31:0] write_to_reg;
    logic        reg_we;
    logic        taken;
    logic        flush;
    logic        ras_ovf;
    logic        ras_udf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        tk;
        logic        we;
        logic [31:0] wtr;
        logic        ovf;
        logic        udf;
    } exp_t;

    exp_t sb[$];

    branch_unit_ras #(
        .XLEN     (32),
        .RAS_DEPTH(4),
        .RESET_PC (RstPc)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .branch      (branch),
        .fn_code     (fn_code),
        .imm         (imm),
        .return_addr (return_addr),
        .flags       (flags),
        .flags_we    (flags_we),
        .pc          (pc),
        .write_to_reg(write_to_reg),
        .reg_we      (reg_we),
        .taken       (taken),
        .flush       (flush),
        .ras_ovf     (ras_ovf),
        .ras_udf     (ras_udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted instruction must match the head of the scoreboard.
    initial begin
        logic acc;
        exp_t e;
        forever begin
            @(posedge clk);
            acc = br_valid && br_ready;
            #1;
            if (acc) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: got accept at pc 0x%0h expected none", pc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_pc"}, pc, e.pc);
                    chk({e.name, "_taken"}, 32'(taken), 32'(e.tk));
                    chk({e.name, "_reg_we"}, 32'(reg_we), 32'(e.we));
                    if (e.we) chk({e.name, "_wtr"}, write_to_reg, e.wtr);
                    chk({e.name, "_ovf"}, 32'(ras_ovf), 32'(e.ovf));
                    chk({e.name, "_udf"}, 32'(ras_udf), 32'(e.udf));
                end
            end
        end
    end

    // Watchdog.
    initial begin
        repeat (3000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    // Entered and left at a negedge; issues one instruction and checks the bubble.
    task automatic send(input string nm, input logic [2:0] br, input logic [5:0] fn,
                        input logic [31:0] im, input logic [31:0] ra, input logic [4:0] fl,
                        input logic fwe, input logic [31:0] epc, input logic etk,
                        input logic ewe, input logic [31:0] ewtr, input logic eovf,
                        input logic eudf);
        exp_t e;
        chk({nm, "_ready"}, 32'(br_ready), 32'd1);
        br_valid    = 1'b1;
        branch      = br;
        fn_code     = fn;
        imm         = im;
        return_addr = ra;
        flags       = fl;
        flags_we    = fwe;
        e = '{name: nm, pc: epc, tk: etk, we: ewe, wtr: ewtr, ovf: eovf, udf: eudf};
        sb.push_back(e);
        @(negedge clk);
        br_valid = 1'b0;
        flags_we = 1'b0;
        chk({nm, "_flush"}, 32'(flush), 32'(etk));
        if (etk) begin
            chk({nm, "_bubble_ready"}, 32'(br_ready), 32'd0);
            // Offer an instruction during the bubble; it must not be accepted.
            br_valid = 1'b1;
            branch   = 3'b000;
            @(negedge clk);
            br_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input string nm, input logic valid_during);
        @(negedge clk);
        rst      = 1'b1;
        br_valid = valid_during;
        branch   = 3'b101;
        imm      = 32'h40;
        repeat (2) @(negedge clk);
        chk({nm, "_ready_in_rst"}, 32'(br_ready), 32'd0);
        rst      = 1'b0;
        br_valid = 1'b0;
        #1;
        chk({nm, "_pc"}, pc, RstPc);
        chk({nm, "_ready"}, 32'(br_ready), 32'd1);
        chk({nm, "_flush"}, 32'(flush), 32'd0);
        chk({nm, "_taken"}, 32'(taken), 32'd0);
        chk({nm, "_reg_we"}, 32'(reg_we), 32'd0);
        chk({nm, "_wtr"}, write_to_reg, 32'd0);
        chk({nm, "_ovf"}, 32'(ras_ovf), 32'd0);
        chk({nm, "_udf"}, 32'(ras_udf), 32'd0);
    endtask

    initial begin
        exp_t e;
        do_reset("reset", 1'b0);

        // Sequential flow, one per cycle.
        send("seq1", 3'b000, 6'd0, 32'h0, 32'h0, 5'h0, 1'b0, 32'h101, 0, 0, 0, 0, 0);
        send("seq2", 3'b000, 6'd0, 32'h0, 32'h0, 5'h0, 1'b0, 32'h102, 0, 0, 0, 0, 0);
        send("seq3", 3'b000, 6'd0, 32'h0, 32'h0, 5'h0, 1'b0, 32'h103, 0, 0, 0, 0, 0);
        // Jump to 0x20 while loading flags=00010.
        send("jump", 3'b001, 6'd0, 32'hFFFF_FF1D, 32'h0, 5'b00010, 1'b1, 32'h20, 1, 0, 0, 0, 0);
        send("cond1", 3'b011, 6'd0, 32'hFFFF_FFFC, 32'h0, 5'h0, 1'b0, 32'h1C, 1, 0, 0, 0, 0);
        // Same-cycle flag write must not affect this branch.
        send("same_cyc", 3'b010, 6'd0, 32'h10, 32'h0, 5'b00001, 1'b1, 32'h1D, 0, 0, 0, 0, 0);
        send("cond0", 3'b010, 6'd0, 32'h10, 32'h0, 5'h0, 1'b0, 32'h2D, 1, 0, 0, 0, 0);
        send("fn_other", 3'b001, 6'd2, 32'h10, 32'h0, 5'h0, 1'b0, 32'h2E, 0, 0, 0, 0, 0);
        send("cond2_nt", 3'b100, 6'd0, 32'h5, 32'h0, 5'h0, 1'b0, 32'h2F, 0, 0, 0, 0, 0);
        send("jump_imm1", 3'b001, 6'd0, 32'h1, 32'h0, 5'h0, 1'b0, 32'h30, 1, 0, 0, 0, 0);
        send("jump_back", 3'b001, 6'd0, 32'hFFFF_FFE0, 32'h0, 5'h0, 1'b0, 32'h10, 1, 0, 0, 0, 0);

        // Five calls; the fifth overflows a 4-deep RAS.
        send("call1", 3'b101, 6'd0, 32'h10, 32'h0, 5'h0, 1'b0, 32'h20, 1, 1, 32'h11, 0, 0);
        send("call2", 3'b101, 6'd0, 32'h10, 32'h0, 5'h0, 1'b0, 32'h30, 1, 1, 32'h21, 0, 0);
        send("call3", 3'b101, 6'd0, 32'h10, 32'h0, 5'h0, 1'b0, 32'h40, 1, 1, 32'h31, 0, 0);
        send("call4", 3'b101, 6'd0, 32'h10, 32'h0, 5'h0, 1'b0, 32'h50, 1, 1, 32'h41, 0, 0);
        send("call5", 3'b101, 6'd0, 32'h10, 32'h0, 5'h0, 1'b0, 32'h60, 1, 1, 32'h51, RasEn, 0);
        send("ret1", 3'b001, 6'd1, 32'h0, 32'h77, 5'h0, 1'b0, RasEn ? 32'h51 : 32'h77, 1, 0, 0, 0, 0);
        send("ret2", 3'b001, 6'd1, 32'h0, 32'h77, 5'h0, 1'b0, RasEn ? 32'h41 : 32'h77, 1, 0, 0, 0, 0);
        send("ret3", 3'b001, 6'd1, 32'h0, 32'h77, 5'h0, 1'b0, RasEn ? 32'h31 : 32'h77, 1, 0, 0, 0, 0);
        send("ret4", 3'b001, 6'd1, 32'h0, 32'h77, 5'h0, 1'b0, RasEn ? 32'h21 : 32'h77, 1, 0, 0, 0, 0);
        send("ret5", 3'b001, 6'd1, 32'h0, 32'h99, 5'h0, 1'b0, 32'h99, 1, 0, 0, 0, RasEn);

        // Leave one entry on the RAS, then reset during the bubble of a taken jump.
        send("call6", 3'b101, 6'd0, 32'h1, 32'h0, 5'h0, 1'b0, 32'h9A, 1, 1, 32'h9A, 0, 0);
        chk("rst_jump_ready", 32'(br_ready), 32'd1);
        br_valid = 1'b1;
        branch   = 3'b001;
        fn_code  = 6'd0;
        imm      = 32'h2;
        e = '{name: "rst_jump", pc: 32'h9C, tk: 1'b1, we: 1'b0, wtr: 32'h0, ovf: 1'b0,
              udf: 1'b0};
        sb.push_back(e);
        @(negedge clk);
        br_valid = 1'b0;
        chk("rst_jump_flush", 32'(flush), 32'd1);
        rst      = 1'b1;
        br_valid = 1'b1;
        branch   = 3'b101;
        @(negedge clk);
        chk("rst_flush_ready", 32'(br_ready), 32'd0);
        rst      = 1'b0;
        br_valid = 1'b0;
        #1;
        chk("rst_flush_pc", pc, RstPc);
        chk("rst_flush_flush", 32'(flush), 32'd0);
        @(negedge clk);
        // RAS must be empty after reset: the return falls back to return_addr.
        send("ret_post_rst", 3'b001, 6'd1, 32'h0, 32'h55, 5'h0, 1'b0, 32'h55, 1, 0, 0, 0, RasEn);

        // Reset with a valid instruction pending: it is dropped.
        do_reset("rst_valid", 1'b1);
        send("post_rst", 3'b000, 6'd0, 32'h0, 32'h0, 5'h0, 1'b0, 32'h101, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_unit_ras.md
# branch_unit_ras

Parametrised branch resolution unit with an owned program counter, registered condition flags, a hardware return-address stack (RAS) and a valid/ready front-end handshake with a one-cycle flush bubble after every taken branch. It sits between decode and instruction fetch, and supersedes the combinational next-PC logic. It drives the fetch PC directly and produces the link value for the register file.

## Interface
- XLEN, 32, PC/immediate/link width
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- br_valid  in  1  decoded instruction presented
- br_ready  out  1  unit can accept an instruction this cycle
- branch  in  3  branch class (encoding below)
- fn_code  in  6  sub-function for branch=001
- imm  in  XLEN  signed word offset
- return_addr  in  XLEN  register-sourced return target
- flags  in  5  ALU flags
- flags_we  in  1  capture flags into flags_q
- pc  out  XLEN  current fetch PC (registered)
- write_to_reg  out  XLEN  link value (registered)
- reg_we  out  1  one-cycle pulse, link value valid
- taken  out  1  one-cycle pulse, last accepted instruction redirected PC
- flush  out  1  high during bubble cycle; fetch discards its instruction
- ras_ovf  out  1  one-cycle pulse, push onto full RAS
- ras_udf  out  1  one-cycle pulse, pop from empty RAS

## Operation
- Accept = br_valid && br_ready. No state changes without accept, except flags_q and reset.
- The next PC is chosen as follows. All sums are modulo 2^XLEN, word-indexed, with imm added two's-complement.
  - 000 or unlisted: PC+1
  - 001, fn 000000: PC+imm (jump)
  - 001, fn 000001: return (see Configuration)
  - 001, other fn: PC+1
  - 010/011/100/110/111: PC+imm if flags_q[0]/[1]/[2]/[3]/[4] set, else PC+1
  - 101 (call): PC+imm. write_to_reg←PC+1, reg_we pulse. PC+1 is pushed on the RAS.
- Conditional branches test flags_q, which is the value registered by an earlier flags_we. When flags_we and a conditional branch are accepted in the same cycle, the branch uses the old flags_q; the new value applies from the next instruction.
- Taken means the next PC ≠ PC+1 by selection, not by value. A jump with imm=1 still counts as taken.
- FSM has two states:
  - RUN: br_ready=1. An accepted taken instruction moves the FSM to FLUSH.
  - FLUSH: br_ready=0, flush=1. Always returns to RUN after one cycle.
- RAS is a circular buffer with a pointer and a count (0..RAS_DEPTH).
  - Push when full: overwrite the oldest entry, count stays at RAS_DEPTH, ras_ovf pulses.
  - Pop when empty: use return_addr, ras_udf pulses, count stays 0.

## Timing
- Reset: pc=RESET_PC, write_to_reg=0, reg_we=0, taken=0, flush=0, ras_ovf=0, ras_udf=0, flags_q=0, RAS count=0, FSM=RUN. br_ready=0 while rst is high and 1 in the first cycle after.
- pc, taken, reg_we, write_to_reg and the RAS pulses update on the edge that accepts the instruction, so they are visible the cycle after accept.
- The cycle after a taken accept is the FLUSH cycle: flush=1 and br_ready=0. The next accept can occur two cycles after the taken accept.
- Non-taken throughput is one instruction per cycle.
- rst asserted during FLUSH or with br_valid high: reset wins. The instruction is dropped and no RAS update occurs.

## Configuration
- BRANCH_RAS_EN defined:
  - The RAS is built.
  - Call pushes onto the RAS.
  - Return pops the RAS and uses the popped value. It uses return_addr only on underflow.
- BRANCH_RAS_EN undefined:
  - No RAS storage.
  - Return always targets return_addr.
  - ras_ovf and ras_udf are tied to 0.
  - Call still writes the link and jumps.

## Test plan
- Reset with RESET_PC=0x100, then 3 accepts with branch=000 → pc 0x101, 0x102, 0x103; flush never asserts; br_ready stays 1.
- flags=5'b00010 with flags_we=1, next cycle branch=011, imm=0xFFFFFFFC at pc=0x20 → pc=0x1C, taken=1, next cycle flush=1 and br_ready=0.
- Same cycle: flags_we=1 with flags[0]=1 and branch=010 while flags_q[0]=0 → not taken, pc+1; a following branch=010 is taken.
- BRANCH_RAS_EN, RAS_DEPTH=4: 5 calls at pc 0x10, 0x20, 0x30, 0x40, 0x50 → the fifth raises ras_ovf; 4 returns yield 0x51, 0x41, 0x31, 0x21; a fifth return with return_addr=0x99 → pc=0x99 and ras_udf=1.
- Without BRANCH_RAS_EN: call at 0x10 then return with return_addr=0x77 → write_to_reg=0x11, reg_we pulse, final pc=0x77, ras flags 0.
- rst asserted during the FLUSH cycle after a taken jump → pc=RESET_PC, flush=0, RAS empty.
